sprite_attack_fetch: RTL
========================

# sprite_attack_fetch

Address generator and pixel qualifier that sits directly upstream of a sprite palette-index ROM (5-bit entries, 1-cycle synchronous read) and consumes that ROM's output. Maps the VGA draw coordinate to a ROM address, sequences a multi-frame attack animation on vertical-sync ticks, and delivers a pipeline-aligned palette index plus a pixel-enable to the colour mapper.

## Interface
- `SPR_W`, 28, sprite width in pixels
- `SPR_H`, 42, sprite height in pixels
- `NUM_FRAMES`, 1, animation frames stacked in ROM (frame f starts at f*SPR_W*SPR_H)
- `HOLD_TICKS`, 4, vsync ticks each frame is shown
- `COOL_TICKS`, 8, vsync ticks of cooldown after the last frame
- `TRANSP_IDX`, 0, palette index treated as transparent

- `Clk`  in  1  system clock (pixel domain)
- `Reset_n`  in  1  asynchronous, active-low reset
- `VGA_VS`  in  1  vertical sync from VGA controller, active-low
- `DrawX`, `DrawY`  in  10 each  current pixel coordinate
- `SprX`, `SprY`  in  10 each  sprite top-left position
- `facing_left`  in  1  horizontal mirror request
- `attack_req`  in  1  single-cycle attack trigger
- `rom_addr`  out  19  ROM read address (registered)
- `rom_data`  in  5  ROM output, valid 1 cycle after `rom_addr`
- `pix_idx`  out  5  palette index (registered)
- `pix_on`  out  1  sprite pixel opaque at this coordinate (registered)
- `busy`  out  1  state != IDLE
- `frame_idx`  out  8  current animation frame

## Operation
- Tick: registered falling edge of `VGA_VS` (1→0); one-cycle pulse, one cycle after the edge is sampled.
- `SprX`/`SprY`/`facing_left` latched into shadow registers on each tick only; all address math uses shadows (no mid-frame tear).
- `attack_req` sets `pending`; cleared when consumed. Requests while not IDLE are dropped (`pending` only set in IDLE).
- FSM: IDLE → ACTIVE on tick with `pending`; `frame_idx`=0, tick count=0. ACTIVE: count ticks; at HOLD_TICKS advance frame; after frame NUM_FRAMES-1 completes HOLD_TICKS → COOLDOWN. COOLDOWN: after COOL_TICKS ticks → IDLE. Tick and request in same cycle in IDLE: request is taken on that tick.
- Hit: col = DrawX − SX, row = DrawY − SY computed 11-bit unsigned; hit when DrawX ≥ SX, DrawY ≥ SY, col < SPR_W, row < SPR_H. Sprites beyond 639/479 clip naturally; no wrap.
- Address = frame_idx*SPR_W*SPR_H + row*SPR_W + col', zero-extended to 19 bits; when not hit, address 0.
- `pix_on` = hit(delayed) ∧ state==ACTIVE ∧ rom_data ≠ TRANSP_IDX. `pix_idx` = rom_data when `pix_on`, else 0.

## Timing
- Reset (async assert, sync deassert release): state IDLE, `pending`=0, shadows 0, `rom_addr`=0, `pix_idx`=0, `pix_on`=0, `busy`=0, `frame_idx`=0.
- Pipeline: coordinate at cycle n → `rom_addr` at n+1 → `rom_data` at n+2 → `pix_on`/`pix_idx` at n+3. Fixed 3-cycle latency; hit and state flags delayed to match.
- Reset mid-animation: immediate return to IDLE, outputs to reset values; in-flight pipeline discarded.
- `busy` rises the cycle after the consuming tick, falls the cycle after the final cooldown tick.

## Configuration
- `SPRITE_MIRROR_EN` defined: col' = SPR_W−1−col when latched `facing_left`=1, else col.
- Not defined: col' = col always; `facing_left` ignored.

## Test plan
- Reset, SprX=100, SprY=200, no attack: sweep full frame → `pix_on` never 1, `rom_addr`=0 outside hit.
- attack_req, then tick: DrawX=100, DrawY=200 → `rom_addr`=0 one cycle later; DrawX=127, DrawY=241 → `rom_addr`=1175; `pix_on` 3 cycles after each iff ROM data ≠ 0.
- NUM_FRAMES=3, HOLD_TICKS=4, COOL_TICKS=8: `frame_idx` 0,1,2 each for 4 ticks, `busy` high 20 ticks total, second attack_req during ACTIVE ignored.
- SPRITE_MIRROR_EN, facing_left=1: DrawX=100, DrawY=200 → `rom_addr`=27; without macro → 0.
- SprX=630: DrawX=639 hits (col 9), DrawX=0 no hit; SprX change mid-frame has no effect until next tick.
- Assert Reset_n low during ACTIVE frame 1 → `busy`,`pix_on`,`frame_idx` 0 immediately; next attack starts at frame 0.

Source files
------------

// File: rtl/sprite_attack_fetch.sv
// ---------------------------------------------------------------------------
// sprite_attack_fetch
//
// Address generator and pixel qualifier for a sprite palette-index ROM
// (5-bit entries, 1-cycle synchronous read). It maps the VGA draw coordinate
// to a ROM address. It steps a multi-frame attack animation on vsync ticks.
// It returns a pipeline-aligned palette index and a pixel-enable.
//
// Optional feature macro: SPRITE_MIRROR_EN
//   When it is defined, the latched facing_left mirrors the sprite column.
//   When it is not defined, facing_left is ignored.
//
// Ports
//   Clk, Reset_n       pixel clock; asynchronous active-low reset
//   VGA_VS             active-low vertical sync; its falling edge is a tick
//   DrawX, DrawY       current pixel coordinate
//   SprX, SprY         sprite top-left position (latched on each tick)
//   facing_left        horizontal mirror request (latched on each tick)
//   attack_req         single-cycle attack trigger
//   rom_addr           registered ROM read address
//   rom_data           ROM output, valid one cycle after rom_addr
//   pix_idx, pix_on    registered palette index and opaque flag (3-cycle latency)
//   busy               animation or cooldown in progress
//   frame_idx          current animation frame
// ---------------------------------------------------------------------------
module sprite_attack_fetch #(
    parameter int         SPR_W      = 28,
    parameter int         SPR_H      = 42,
    parameter int         NUM_FRAMES = 1,
    parameter int         HOLD_TICKS = 4,
    parameter int         COOL_TICKS = 8,
    parameter logic [4:0] TRANSP_IDX = 5'd0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        VGA_VS,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  SprX,
    input  logic [9:0]  SprY,
    input  logic        facing_left,
    input  logic        attack_req,
    output logic [18:0] rom_addr,
    input  logic [4:0]  rom_data,
    output logic [4:0]  pix_idx,
    output logic        pix_on,
    output logic        busy,
    output logic [7:0]  frame_idx
);

    typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} state_e;

    localparam logic [10:0] SPR_W11    = 11'(SPR_W);
    localparam logic [10:0] SPR_H11    = 11'(SPR_H);
    localparam logic [18:0] SPR_W19    = 19'(SPR_W);
    localparam logic [18:0] FRAME_SZ   = 19'(SPR_W * SPR_H);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_TICKS - 1);
    localparam logic [7:0]  COOL_LAST  = 8'(COOL_TICKS - 1);
    localparam logic [7:0]  FRAME_LAST = 8'(NUM_FRAMES - 1);

    state_e      state_q;
    logic        vs_q, tick_q, pending_q, busy_q;
    logic [7:0]  frame_q, tcnt_q;
    logic [9:0]  sx_q, sy_q;
    logic [18:0] rom_addr_q;
    logic        qual_q1, qual_q2;
    logic        pix_on_q;
    logic [4:0]  pix_idx_q;

`ifdef SPRITE_MIRROR_EN
    logic        facing_q;
`else
    logic        unused_facing;
    assign unused_facing = facing_left;
`endif

    // Combinational hit test and address, based on the tick-latched shadows.
    logic [10:0] col, row, col_m;
    logic        hit;
    logic [18:0] addr_d;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        col    = {1'b0, DrawX} - {1'b0, sx_q};
        row    = {1'b0, DrawY} - {1'b0, sy_q};
        hit    = (DrawX >= sx_q) && (DrawY >= sy_q) && (col < SPR_W11) && (row < SPR_H11);
`ifdef SPRITE_MIRROR_EN
        col_m  = facing_q ? (SPR_W11 - 11'd1 - col) : col;
`else
        col_m  = col;
`endif
        addr_d = 19'(frame_q) * FRAME_SZ + 19'(row) * SPR_W19 + 19'(col_m);
    end

    // Tick detection, shadow latching and the animation FSM.
    // NOTE: sequential state uses non-blocking assignments only, so every register reads pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_q      <= 1'b0;
            tick_q    <= 1'b0;
            sx_q      <= '0;
            sy_q      <= '0;
`ifdef SPRITE_MIRROR_EN
            facing_q  <= 1'b0;
`endif
            state_q   <= IDLE;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            frame_q   <= '0;
            tcnt_q    <= '0;
        end else begin
            vs_q   <= VGA_VS;
            tick_q <= vs_q & ~VGA_VS;
            if (tick_q) begin
                sx_q <= SprX;
                sy_q <= SprY;
`ifdef SPRITE_MIRROR_EN
                facing_q <= facing_left;
`endif
            end
            case (state_q)
                IDLE: begin
                    // A request on the same cycle as the tick starts the attack.
                    if (tick_q && (pending_q || attack_req)) begin
                        state_q   <= ACTIVE;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                        frame_q   <= '0;
                        tcnt_q    <= '0;
                    end else if (attack_req) begin
                        pending_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (tick_q) begin
                        if (tcnt_q == HOLD_LAST) begin
                            tcnt_q <= '0;
                            if (frame_q == FRAME_LAST) state_q <= COOLDOWN;
                            else                       frame_q <= frame_q + 8'd1;
                        end else begin
                            tcnt_q <= tcnt_q + 8'd1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (tick_q) begin
                        if (tcnt_q == COOL_LAST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            frame_q <= '0;
                            tcnt_q  <= '0;
                        end else begin
                            tcnt_q <= tcnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pixel pipeline. The qualifier (hit and ACTIVE) is sampled together with
    // the coordinate and delayed twice, so that it lines up with rom_data.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
            qual_q1    <= 1'b0;
            qual_q2    <= 1'b0;
            pix_on_q   <= 1'b0;
            pix_idx_q  <= '0;
        end else begin
            rom_addr_q <= hit ? addr_d : '0;
            qual_q1    <= hit && (state_q == ACTIVE);
            qual_q2    <= qual_q1;
            pix_on_q   <= qual_q2 && (rom_data != TRANSP_IDX);
            pix_idx_q  <= (qual_q2 && (rom_data != TRANSP_IDX)) ? rom_data : '0;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix_on    = pix_on_q;
    assign pix_idx   = pix_idx_q;
    assign busy      = busy_q;
    assign frame_idx = frame_q;

endmodule
